operand_sel_stage: RTL and testbench

Registered operand-selection stage between decode and execute. It generalises the combinational ALU/AGU/CSR source selectors into one pipeline stage. The stage resolves register operands through a parametrised forwarding network, muxes the final ALU A/B, AGU base, CSR source and store data, and registers them behind a valid/ready handshake. It stalls on load-use style hazards, supports flush, and counts stall cycles.

---
 rtl/operand_sel_stage.sv | 152 +++++++++++++++
 tb/tb_operand_sel_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_sel_stage.sv
// Registered operand-selection stage: resolves rs1/rs2 through a priority
// forwarding network, muxes ALU/AGU/CSR/store operands and registers them.
module operand_sel_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned RAW     = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [RAW-1:0]          rs1_idx,
  input  logic [RAW-1:0]          rs2_idx,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         imm,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_pending,
  input  logic [NUM_FWD*RAW-1:0]  fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         alu_a,
  output logic [XLEN-1:0]         alu_b,
  output logic [XLEN-1:0]         agu_base,
  output logic [XLEN-1:0]         csr_src,
  output logic [XLEN-1:0]         st_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_IMM   = 7'b0010011,
    OP_AUIPC = 7'b0010111,
    OP_STORE = 7'b0100011,
    OP_R     = 7'b0110011,
    OP_LUI   = 7'b0110111,
    OP_BR    = 7'b1100011,
    OP_JALR  = 7'b1100111,
    OP_JAL   = 7'b1101111,
    OP_SYS   = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic            haz;
    logic [XLEN-1:0] val;
  } opnd_t;

  // Lowest matching index wins, even if it is pending and a later one is not.
  function automatic opnd_t resolve(input logic [RAW-1:0] idx, input logic [XLEN-1:0] rf);
    opnd_t r;
    logic  hit;
    r.haz = 1'b0;
    r.val = rf;
    hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!hit && fwd_valid[i] && (fwd_rd[i*RAW +: RAW] == idx)) begin
        hit   = 1'b1;
        r.haz = fwd_pending[i];
        r.val = fwd_data[i*XLEN +: XLEN];
      end
    end
    if (idx == '0) begin
      r.haz = 1'b0;
      r.val = '0;
    end
    return r;
  endfunction

  opnd_t rs1_op, rs2_op;
  logic  rs1_used, rs2_used, hazard, xfer, csr_reg, csr_imm;
  logic [XLEN-1:0] alu_a_d, alu_b_d, agu_d, csr_d, st_d;
  logic [XLEN-1:0] alu_a_q, alu_b_q, agu_q, csr_q, st_q;
  logic            valid_q;
  logic [CNT_W-1:0] stall_q;

  always_comb begin
    rs1_op   = resolve(rs1_idx, rs1_data);
    rs2_op   = resolve(rs2_idx, rs2_data);
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    alu_a_d  = '0;
    alu_b_d  = '0;
    agu_d    = '0;
    csr_d    = '0;
    st_d     = '0;
    csr_reg  = funct3 inside {3'b001, 3'b010, 3'b011};
    csr_imm  = funct3 inside {3'b101, 3'b110, 3'b111};
    case (opcode)
      OP_R:     begin rs1_used = 1'b1; rs2_used = 1'b1; alu_a_d = rs1_op.val; alu_b_d = rs2_op.val; end
      OP_IMM:   begin rs1_used = 1'b1; alu_a_d = rs1_op.val; alu_b_d = imm; end
      OP_BR:    begin
                  rs1_used = 1'b1; rs2_used = 1'b1;
                  alu_a_d = rs1_op.val; alu_b_d = rs2_op.val; agu_d = pc;
                end
      OP_LOAD:  begin rs1_used = 1'b1; agu_d = rs1_op.val; end
      OP_STORE: begin rs1_used = 1'b1; rs2_used = 1'b1; agu_d = rs1_op.val; st_d = rs2_op.val; end
      OP_JALR:  begin rs1_used = 1'b1; alu_a_d = pc; alu_b_d = XLEN'(3'd4); agu_d = rs1_op.val; end
      OP_JAL:   begin alu_a_d = pc; alu_b_d = XLEN'(3'd4); agu_d = pc; end
      OP_AUIPC: begin alu_a_d = pc; alu_b_d = imm; end
      OP_LUI:   alu_b_d = imm;
      OP_SYS:   begin
                  rs1_used = csr_reg;
                  if (csr_reg)      csr_d = rs1_op.val;
                  else if (csr_imm) csr_d = XLEN'(rs1_idx);
                end
      default:  ;
    endcase
    hazard   = in_valid & ((rs1_used & rs1_op.haz) | (rs2_used & rs2_op.haz));
    in_ready = ~flush & ~hazard & (~valid_q | out_ready);
    xfer     = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      agu_q   <= '0;
      csr_q   <= '0;
      st_q    <= '0;
      stall_q <= '0;
    end else begin
      if (xfer) begin
        valid_q <= 1'b1;
        alu_a_q <= alu_a_d;
        alu_b_q <= alu_b_d;
        agu_q   <= agu_d;
        csr_q   <= csr_d;
        st_q    <= st_d;
      end else if (flush || out_ready) begin
        valid_q <= 1'b0;
      end
      if (hazard && !flush && !(&stall_q))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign agu_base  = agu_q;
  assign csr_src   = csr_q;
  assign st_data   = st_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed bench for operand_sel_stage: a cycle model predicts in_ready,
// out_valid and stall_cnt; expected operands queue up on acceptance.
module tb_operand_sel_stage;

  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_data, rs2_data, pc, imm;
  logic [2:0]  fwd_valid, fwd_pending;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic [31:0] alu_a, alu_b, agu_base, csr_src, st_data;
  logic [3:0]  stall_cnt;

  operand_sel_stage #(.XLEN(32), .NUM_FWD(3), .RAW(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .agu_base(agu_base), .csr_src(csr_src), .st_data(st_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, agu, csr, st;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mv    = 1'b0;
  int   mcnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] a, b, agu, csr, st);
    rec_t r;
    r.a = a; r.b = b; r.agu = agu; r.csr = csr; r.st = st;
    return r;
  endfunction

  task automatic instr(input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2,
                       input logic [31:0] p, input logic [31:0] im);
    in_valid = 1'b1; opcode = op; funct3 = f3;
    rs1_idx = r1; rs1_data = d1; rs2_idx = r2; rs2_data = d2; pc = p; imm = im;
  endtask

  task automatic fwd_clear();
    fwd_valid = '0; fwd_pending = '0; fwd_rd = '0; fwd_data = '0;
  endtask

  // Inputs are already driven (one step after a rising edge); one clock elapses.
  task automatic tick(input bit op_haz, input rec_t e);
    bit rdy;
    #1;
    rdy = !flush && !(in_valid && op_haz) && (!mv || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    if (mv && exp_q.size() > 0) begin
      chk("alu_a", alu_a, exp_q[0].a);
      chk("alu_b", alu_b, exp_q[0].b);
      chk("agu_base", agu_base, exp_q[0].agu);
      chk("csr_src", csr_src, exp_q[0].csr);
      chk("st_data", st_data, exp_q[0].st);
      if (out_ready || flush) void'(exp_q.pop_front());
    end
    if (in_valid && rdy) begin
      exp_q.push_back(e);
      mv = 1'b1;
    end else if (flush || out_ready) begin
      mv = 1'b0;
    end
    if (in_valid && op_haz && !flush && mcnt < CMAX) mcnt++;
    @(posedge clk); #1;
    chk("stall_cnt", {28'b0, stall_cnt}, mcnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_agu_base", agu_base, 32'd0);
    chk("rst_csr_src", csr_src, 32'd0);
    chk("rst_st_data", st_data, 32'd0);
    chk("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
    rst = 1'b0;
    mv = 1'b0; mcnt = 0; exp_q.delete();
  endtask

  rec_t none;

  initial begin
    none = mk(0, 0, 0, 0, 0);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; rs1_idx = '0; rs2_idx = '0;
    rs1_data = '0; rs2_data = '0; pc = '0; imm = '0;
    fwd_clear();
    do_reset();

    // ADD x1=5, x2=7
    instr(7'b0110011, 3'b000, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 32'h0);
    tick(0, mk(5, 7, 0, 0, 0));

    // ADDI rs1=x1 with two matching forwards: index 0 wins
    instr(7'b0010011, 3'b000, 5'd1, 32'd5, 5'd0, 32'd0, 32'h0, 32'd3);
    fwd_valid = 3'b011; fwd_rd[4:0] = 5'd1; fwd_rd[9:5] = 5'd1;
    fwd_data[31:0] = 32'hAA; fwd_data[63:32] = 32'hBB;
    tick(0, mk(32'hAA, 3, 0, 0, 0));

    // x0 never forwards, even against a forward to rd 0
    fwd_rd[4:0] = 5'd0;
    instr(7'b0010011, 3'b000, 5'd0, 32'd9, 5'd0, 32'd0, 32'h0, 32'd3);
    tick(0, mk(0, 3, 0, 0, 0));

    // SW with rs2=x3: pending index 0 not masked by ready index 1
    instr(7'b0100011, 3'b010, 5'd6, 32'h100, 5'd3, 32'hDEAD, 32'h0, 32'd8);
    fwd_valid = 3'b011; fwd_pending = 3'b001;
    fwd_rd[4:0] = 5'd3; fwd_rd[9:5] = 5'd3;
    fwd_data[31:0] = 32'h0; fwd_data[63:32] = 32'h5555;
    tick(1, none);
    tick(1, none);
    fwd_pending = 3'b000; fwd_data[31:0] = 32'h1234;
    tick(0, mk(0, 0, 32'h100, 0, 32'h1234));
    chk("loaduse_stall_cnt", {28'b0, stall_cnt}, 32'd2);

    in_valid = 1'b0; fwd_clear();
    tick(0, none);

    // Backpressure across three JALs
    out_ready = 1'b0;
    instr(7'b1101111, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 32'h80000000, 32'h0);
    tick(0, mk(32'h80000000, 4, 32'h80000000, 0, 0));
    tick(0, mk(32'h80000000, 4, 32'h80000000, 0, 0));
    tick(0, mk(32'h80000000, 4, 32'h80000000, 0, 0));
    out_ready = 1'b1;
    tick(0, mk(32'h80000000, 4, 32'h80000000, 0, 0));
    in_valid = 1'b0;
    tick(0, none);
    tick(0, none);

    // Mixed opcodes back to back
    instr(7'b1100011, 3'b000, 5'd1, 32'd10, 5'd2, 32'd20, 32'h40, 32'h0);
    tick(0, mk(10, 20, 32'h40, 0, 0));
    instr(7'b1100111, 3'b000, 5'd5, 32'h200, 5'd0, 32'd0, 32'h44, 32'h0);
    tick(0, mk(32'h44, 4, 32'h200, 0, 0));
    fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd[4:0] = 5'd3;
    instr(7'b0110111, 3'b000, 5'd3, 32'd0, 5'd3, 32'd0, 32'h48, 32'h12345000);
    tick(0, mk(0, 32'h12345000, 0, 0, 0));
    fwd_clear();
    instr(7'b0010111, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 32'h4C, 32'h1000);
    tick(0, mk(32'h4C, 32'h1000, 0, 0, 0));
    instr(7'b0000011, 3'b010, 5'd7, 32'h300, 5'd0, 32'd0, 32'h50, 32'h4);
    tick(0, mk(0, 0, 32'h300, 0, 0));
    instr(7'b1110011, 3'b001, 5'd2, 32'h77, 5'd0, 32'd0, 32'h54, 32'h0);
    tick(0, mk(0, 0, 0, 32'h77, 0));
    instr(7'b1110011, 3'b101, 5'd17, 32'hDEAD, 5'd0, 32'd0, 32'h58, 32'h0);
    tick(0, mk(0, 0, 0, 17, 0));
    instr(7'b0010011, 3'b000, 5'd1, 32'd1, 5'd0, 32'd0, 32'h5C, 32'h1);
    tick(0, mk(1, 1, 0, 0, 0));

    // Flush while holding an entry
    out_ready = 1'b0;
    instr(7'b1110011, 3'b101, 5'd17, 32'h0, 5'd0, 32'd0, 32'h60, 32'h0);
    tick(0, mk(0, 0, 0, 17, 0));
    flush = 1'b1;
    instr(7'b0110011, 3'b000, 5'd1, 32'd1, 5'd2, 32'd2, 32'h64, 32'h0);
    tick(0, none);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(0, none);

    // Stall counter saturation, then reset mid-stall
    do_reset();
    instr(7'b0110011, 3'b000, 5'd1, 32'd3, 5'd2, 32'd4, 32'h0, 32'h0);
    tick(0, mk(3, 4, 0, 0, 0));
    out_ready = 1'b0;
    fwd_valid = 3'b001; fwd_pending = 3'b001; fwd_rd[4:0] = 5'd1;
    for (int n = 0; n < 20; n++) tick(1, none);
    chk("sat_stall_cnt", {28'b0, stall_cnt}, 32'd15);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
